// File: rtl/maze_pkg.sv
// Shared types for the parametrised maze walker: cell codes, headings, FSM states
// and the heading/passability helpers used by the walker.
package maze_pkg;

  typedef enum logic [1:0] {
    CELL_PATH    = 2'd0,
    CELL_WALL    = 2'd1,
    CELL_SWORD   = 2'd2,
    CELL_MONSTER = 2'd3
  } cell_t;

  typedef enum logic [1:0] {
    DIR_R = 2'd0,
    DIR_D = 2'd1,
    DIR_L = 2'd2,
    DIR_U = 2'd3
  } dir_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_FILL,
    ST_WALK,
    ST_DONE
  } state_t;

  // Headings are ordered clockwise, so a right turn is +1 and a left turn is -1.
  function automatic dir_t turn_r(dir_t d);
    return dir_t'(d + 2'd1);
  endfunction

  function automatic dir_t turn_l(dir_t d);
    return dir_t'(d - 2'd1);
  endfunction

  function automatic logic passable(logic [1:0] code, logic sword);
    return (code == CELL_PATH) || (code == CELL_SWORD) ||
           ((code == CELL_MONSTER) && sword);
  endfunction

endpackage

// File: rtl/maze_cell.sv
// One maze cell: holds its 2-bit code, flags itself as a dead end during fill
// and turns into a wall when the fill step is enabled.
module maze_cell
  import maze_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load_en,
  input  logic [1:0] in,
  input  logic       fill_en,
  input  logic       clear,
  input  logic [1:0] nbr_r,
  input  logic [1:0] nbr_d,
  input  logic [1:0] nbr_l,
  input  logic [1:0] nbr_u,
  input  logic [3:0] edge_mask,
  input  logic       is_endpoint,
  output logic [1:0] code,
  output logic       changed
);

  logic [3:0] blocked;
  logic [2:0] n_blocked;

  always_comb begin
    blocked[0] = edge_mask[0] | (nbr_r == CELL_WALL);
    blocked[1] = edge_mask[1] | (nbr_d == CELL_WALL);
    blocked[2] = edge_mask[2] | (nbr_l == CELL_WALL);
    blocked[3] = edge_mask[3] | (nbr_u == CELL_WALL);
    n_blocked  = 3'(blocked[0]) + 3'(blocked[1]) + 3'(blocked[2]) + 3'(blocked[3]);
    // Swords are never pruned; monsters are, since a dead-end monster is unreachable payoff.
    changed    = !is_endpoint && ((code == CELL_PATH) || (code == CELL_MONSTER)) &&
                 (n_blocked >= 3'd3);
  end

  always_ff @(posedge clk) begin
    if (rst || clear)
      code <= CELL_PATH;
    else if (load_en)
      code <= in;
    else if (fill_en && changed)
      code <= CELL_WALL;
  end

endmodule

// File: rtl/maze_walker_param.sv
// N x N maze solver: streams the maze in, prunes dead ends in parallel, then
// walks (0,0) -> (N-1,N-1) with a right- or left-hand wall follower, one move per cycle.
//
// state   | meaning
// IDLE    | waiting for the first cell beat of a maze
// LOAD    | writing row-major beats into the cell array
// FILL    | pruning dead ends until a cycle with no change
// WALK    | issuing one registered move per cycle
// DONE    | pulse done/abort, clear cells and walker state
module maze_walker_param
  import maze_pkg::*;
#(
  parameter int N         = 17,
  parameter int MAX_STEPS = 4095,
  parameter int CW        = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [1:0]    in,
  input  logic          hand_sel,
  output logic          out_valid,
  output logic [1:0]    out,
  output logic          done,
  output logic          abort,
  output logic [CW-1:0] step_cnt
);

  localparam int NC = N * N;
  localparam int RW = $clog2(N);
  localparam int IW = $clog2(NC);

  state_t        state, state_nxt;
  logic [RW-1:0] row, col, pos_r, pos_c, nxt_r, nxt_c;
  dir_t          heading, move_dir;
  logic          has_sword, hand, abort_pend;
  logic          load_now, fill_en, clear_all, walk_en, last_beat;
  logic [1:0]    cell_code [NC];
  logic [NC-1:0] changed_vec;
  logic [IW-1:0] idx_here;
  logic [1:0]    nbr_code [4];
  logic [3:0]    pass;
  dir_t          cand [4];
  logic          move_ok, goal_hit, limit_hit;
  logic [1:0]    tgt_code;

  assign last_beat = (row == RW'(N-1)) && (col == RW'(N-1));

  for (genvar r = 0; r < N; r++) begin : g_row
    for (genvar c = 0; c < N; c++) begin : g_col
      localparam int K = r * N + c;
      logic [1:0] nr, nd, nl, nu;
      if (c < N-1) begin : g_r assign nr = cell_code[K+1]; end
      else begin : g_rw assign nr = CELL_WALL; end
      if (r < N-1) begin : g_d assign nd = cell_code[K+N]; end
      else begin : g_dw assign nd = CELL_WALL; end
      if (c > 0) begin : g_l assign nl = cell_code[K-1]; end
      else begin : g_lw assign nl = CELL_WALL; end
      if (r > 0) begin : g_u assign nu = cell_code[K-N]; end
      else begin : g_uw assign nu = CELL_WALL; end

      maze_cell u_cell (
        .clk        (clk),
        .rst        (rst),
        .load_en    (load_now && (row == RW'(r)) && (col == RW'(c))),
        .in         (in),
        .fill_en    (fill_en),
        .clear      (clear_all),
        .nbr_r      (nr),
        .nbr_d      (nd),
        .nbr_l      (nl),
        .nbr_u      (nu),
        .edge_mask  ({(r == 0), (c == 0), (r == N-1), (c == N-1)}),
        .is_endpoint((K == 0) || (K == NC-1)),
        .code       (cell_code[K]),
        .changed    (changed_vec[K])
      );
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (in_valid) state_nxt = ST_LOAD;
      ST_LOAD: if (in_valid && last_beat) state_nxt = ST_FILL;
      ST_FILL: if (!(|changed_vec)) state_nxt = ST_WALK;
      ST_WALK: if (!move_ok || goal_hit || limit_hit) state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    load_now  = 1'b0;
    fill_en   = 1'b0;
    walk_en   = 1'b0;
    clear_all = 1'b0;
    case (state)
      ST_IDLE, ST_LOAD: load_now = in_valid;
      ST_FILL:          fill_en  = 1'b1;
      ST_WALK:          walk_en  = 1'b1;
      ST_DONE:          clear_all = 1'b1;
      default: ;
    endcase
  end

  // Wall follower: probe four neighbours, pick the first passable one in hand priority.
  always_comb begin
    idx_here = IW'(pos_r) * IW'(N) + IW'(pos_c);
    for (int d = 0; d < 4; d++) nbr_code[d] = CELL_WALL;
    if (pos_c != RW'(N-1)) nbr_code[DIR_R] = cell_code[idx_here + IW'(1)];
    if (pos_r != RW'(N-1)) nbr_code[DIR_D] = cell_code[idx_here + IW'(N)];
    if (pos_c != '0)       nbr_code[DIR_L] = cell_code[idx_here - IW'(1)];
    if (pos_r != '0)       nbr_code[DIR_U] = cell_code[idx_here - IW'(N)];
    for (int d = 0; d < 4; d++) pass[d] = passable(nbr_code[d], has_sword);
    cand[0] = hand ? turn_l(heading) : turn_r(heading);
    cand[1] = heading;
    cand[2] = hand ? turn_r(heading) : turn_l(heading);
    cand[3] = turn_r(turn_r(heading));
    move_ok  = 1'b0;
    move_dir = heading;
    for (int i = 3; i >= 0; i--) begin
      if (pass[cand[i]]) begin
        move_ok  = 1'b1;
        move_dir = cand[i];
      end
    end
    nxt_r = pos_r;
    nxt_c = pos_c;
    case (move_dir)
      DIR_R: nxt_c = pos_c + RW'(1);
      DIR_D: nxt_r = pos_r + RW'(1);
      DIR_L: nxt_c = pos_c - RW'(1);
      DIR_U: nxt_r = pos_r - RW'(1);
      default: ;
    endcase
    tgt_code  = nbr_code[move_dir];
    goal_hit  = move_ok && (nxt_r == RW'(N-1)) && (nxt_c == RW'(N-1));
    limit_hit = move_ok && (step_cnt == CW'(MAX_STEPS-1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out        <= '0;
      done       <= 1'b0;
      abort      <= 1'b0;
      step_cnt   <= '0;
      row        <= '0;
      col        <= '0;
      pos_r      <= '0;
      pos_c      <= '0;
      heading    <= DIR_R;
      has_sword  <= 1'b0;
      hand       <= 1'b0;
      abort_pend <= 1'b0;
    end else begin
      done  <= 1'b0;
      abort <= 1'b0;
      if (load_now) begin
        if (state == ST_IDLE) begin
          hand     <= hand_sel;
          step_cnt <= '0;
        end
        if (col == RW'(N-1)) begin
          col <= '0;
          row <= (row == RW'(N-1)) ? '0 : row + RW'(1);
        end else begin
          col <= col + RW'(1);
        end
      end
      if (walk_en) begin
        if (move_ok) begin
          out_valid <= 1'b1;
          out       <= move_dir;
          pos_r     <= nxt_r;
          pos_c     <= nxt_c;
          heading   <= move_dir;
          step_cnt  <= step_cnt + CW'(1);
          if (tgt_code == CELL_SWORD) has_sword <= 1'b1;
          if (limit_hit && !goal_hit) abort_pend <= 1'b1;
        end else begin
          out_valid  <= 1'b0;
          out        <= '0;
          abort_pend <= 1'b1;
        end
      end
      if (clear_all) begin
        out_valid  <= 1'b0;
        out        <= '0;
        done       <= 1'b1;
        abort      <= abort_pend;
        abort_pend <= 1'b0;
        pos_r      <= '0;
        pos_c      <= '0;
        heading    <= DIR_R;
        has_sword  <= 1'b0;
        row        <= '0;
        col        <= '0;
      end
    end
  end

endmodule

// File: tb/tb_maze_walker_param.sv
// Directed bench for maze_walker_param at N=5, MAX_STEPS=20 with hand-derived move lists.
module tb_maze_walker_param;

  localparam int N  = 5;
  localparam int MS = 20;
  localparam int CW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic [1:0]    in_d;
  logic          hand_sel;
  logic          out_valid;
  logic [1:0]    out_d;
  logic          done;
  logic          abort;
  logic [CW-1:0] step_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  maze_walker_param #(.N(N), .MAX_STEPS(MS), .CW(CW)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in       (in_d),
    .hand_sel (hand_sel),
    .out_valid(out_valid),
    .out      (out_d),
    .done     (done),
    .abort    (abort),
    .step_cnt (step_cnt)
  );

  // 0 path, 1 wall, 2 sword, 3 monster; row-major
  int m_open[25]  = '{0,0,0,0,0, 0,0,0,0,0, 0,0,0,0,0, 0,0,0,0,0, 0,0,0,0,0};
  int m_branch[25] = '{0,0,0,1,1, 1,1,0,1,1, 0,0,0,1,1, 1,1,0,1,1, 1,1,0,0,0};
  int m_sword[25] = '{0,0,0,3,0, 1,2,1,1,0, 1,1,1,1,0, 1,1,1,1,0, 1,1,1,1,0};
  int m_nosw[25]  = '{0,0,0,3,0, 1,1,1,1,0, 1,1,1,1,0, 1,1,1,1,0, 1,1,1,1,0};
  int m_loop[25]  = '{0,0,0,1,1, 0,1,0,1,1, 0,0,0,1,1, 1,1,1,1,1, 1,1,1,1,0};
  int m_iso[25]   = '{0,3,0,0,0, 1,0,0,0,0, 0,0,0,0,0, 0,0,0,0,0, 0,0,0,0,0};

  // moves: 0 R, 1 D, 2 L, 3 U
  int v_open_r[20] = '{1,1,1,1,0,0,0,0, 0,0,0,0,0,0,0,0,0,0,0,0};
  int v_open_l[20] = '{0,0,0,0,1,1,1,1, 0,0,0,0,0,0,0,0,0,0,0,0};
  int v_branch[20] = '{0,0,1,1,1,1,0,0, 0,0,0,0,0,0,0,0,0,0,0,0};
  int v_sword[20]  = '{0,1,3,0,0,0,1,1,1,1, 0,0,0,0,0,0,0,0,0,0};
  int v_nosw[20]   = '{0,0,2,2,0,0,2,2,0,0,2,2,0,0,2,2,0,0,2,2};
  int v_loop[20]   = '{1,1,0,0,3,3,2,2,1,1,0,0,3,3,2,2,1,1,0,0};
  int v_none[20]   = '{0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic load(input int m[25], input logic hs, input int gap_at);
    for (int k = 0; k < N*N; k++) begin
      if (k == gap_at) begin
        @(negedge clk);
        in_valid = 1'b0;
        in_d     = 2'd3;
      end
      @(negedge clk);
      in_valid = 1'b1;
      in_d     = 2'(m[k]);
      hand_sel = (k == 0) ? hs : ~hs;
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_d     = 2'd0;
  endtask

  // lat: cycle of first move (n>0) or of done (n==0), counted from the last beat
  task automatic run(input string name, input int m[25], input logic hs, input int gap_at,
                     input int mv[20], input int n, input logic ab, input int lat);
    int got = 0;
    int first = 0;
    int donecyc = 0;
    int lastv = 0;
    load(m, hs, gap_at);
    for (int cyc = 1; cyc <= 80; cyc++) begin
      if (cyc > 1) @(negedge clk);
      if (out_valid) begin
        if (first == 0) first = cyc;
        if (got < n) chk({name, "_move"}, 32'(out_d), 32'(mv[got]));
        got++;
        lastv = cyc;
      end
      if (done) begin
        donecyc = cyc;
        break;
      end
    end
    if (donecyc == 0) chk({name, "_done_timeout"}, 32'd0, 32'd1);
    chk({name, "_nmoves"}, 32'(got), 32'(n));
    chk({name, "_step_cnt"}, 32'(step_cnt), 32'(n));
    chk({name, "_abort"}, 32'(abort), 32'(ab));
    chk({name, "_out_valid_at_done"}, 32'(out_valid), 32'd0);
    chk({name, "_out_at_done"}, 32'(out_d), 32'd0);
    if (n > 0) begin
      chk({name, "_latency"}, 32'(first), 32'(lat));
      chk({name, "_done_after_last"}, 32'(donecyc), 32'(lastv + 1));
    end else begin
      chk({name, "_done_latency"}, 32'(donecyc), 32'(lat));
    end
    @(negedge clk);
    chk({name, "_done_pulse"}, 32'(done), 32'd0);
    chk({name, "_abort_pulse"}, 32'(abort), 32'd0);
    chk({name, "_step_cnt_held"}, 32'(step_cnt), 32'(n));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    rst      = 1'b1;
    in_valid = 1'b0;
    in_d     = 2'd0;
    hand_sel = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_abort", 32'(abort), 32'd0);
    chk("rst_step_cnt", 32'(step_cnt), 32'd0);
    chk("rst_out", 32'(out_d), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    run("open_right", m_open,   1'b0, -1, v_open_r, 8,  1'b0, 3);
    run("open_left",  m_open,   1'b1, -1, v_open_l, 8,  1'b0, 3);
    run("branch",     m_branch, 1'b0, 7,  v_branch, 8,  1'b0, 5);
    run("sword",      m_sword,  1'b0, -1, v_sword,  10, 1'b0, 3);
    run("no_sword",   m_nosw,   1'b0, -1, v_nosw,   20, 1'b1, 3);
    run("loop_limit", m_loop,   1'b0, -1, v_loop,   20, 1'b1, 3);
    run("isolated",   m_iso,    1'b0, -1, v_none,   0,  1'b1, 4);

    // reset in the middle of a walk, after three moves
    load(m_open, 1'b0, -1);
    seen = 0;
    for (int cyc = 0; cyc < 40 && seen < 3; cyc++) begin
      if (cyc > 0) @(negedge clk);
      if (out_valid) seen++;
    end
    chk("midrst_reached", 32'(seen), 32'd3);
    chk("midrst_step_cnt_before", 32'(step_cnt), 32'd3);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_step_cnt", 32'(step_cnt), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    repeat (3) @(negedge clk);
    chk("midrst_idle_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_idle_done", 32'(done), 32'd0);
    run("after_rst", m_branch, 1'b0, -1, v_branch, 8, 1'b0, 5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
